// File: rtl/imem_responder.sv
// Instruction memory with a byte-stream program loader and a 1-cycle fetch port
// that returns a 10-byte window at the requested PC.
module imem_responder #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [63:0] load_base,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    input  logic        load_done,
    output logic        load_overflow,
    input  logic        req_valid,
    input  logic [63:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [79:0] rsp_bytes,
    output logic        rsp_error
);
    localparam int          AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] LIMIT   = 64'(MEM_BYTES);
    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 10);

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_ptr;
    logic        r_ovf;
    logic        r_rsp_valid;
    logic [79:0] r_rsp_bytes;
    logic        r_rsp_error;
    logic [7:0]  r_mem [MEM_BYTES];

    logic          w_load_ready, w_req_ready;
    logic          w_in_load, w_we, w_ovf_set, w_accept, w_err;
    logic [AW-1:0] w_idx;
    logic [79:0]   w_win;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load_ready = 1'b0;
        w_req_ready  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (load_start) w_next = LOADING;
            end
            LOADING: begin
                w_load_ready = (r_ptr < LIMIT) && !load_start;
                if (load_start)     w_next = LOADING;
                else if (load_done) w_next = READY;
            end
            READY: begin
                w_req_ready = !load_start && (!r_rsp_valid || rsp_ready);
                if (load_start) w_next = LOADING;
            end
            default: w_next = EMPTY;
        endcase
    end

    assign w_in_load = (r_state == LOADING) && !load_start;
    assign w_we      = w_in_load && load_valid && w_load_ready;
    assign w_ovf_set = w_in_load && load_valid && (r_ptr >= LIMIT);
    assign w_accept  = req_valid && w_req_ready;
    // Unsigned 64-bit compare: PCs near 2^64 must not wrap into range.
    assign w_err     = req_pc > LAST_PC;
    assign w_idx     = req_pc[AW-1:0];

    always_comb begin
        w_win = '0;
        if (!w_err) begin
            for (int i = 0; i < 10; i++) w_win[8*i +: 8] = r_mem[w_idx + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_ovf       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_bytes <= '0;
            r_rsp_error <= 1'b0;
        end else if (load_start) begin
            r_ptr       <= load_base;
            r_ovf       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_we)      r_ptr <= r_ptr + 64'd1;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_bytes <= w_win;
                r_rsp_error <= w_err;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Memory is never reset; a reset cycle blocks the write instead.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) r_mem[r_ptr[AW-1:0]] <= load_byte;
    end

    assign load_ready    = w_load_ready;
    assign req_ready     = w_req_ready;
    assign load_overflow = r_ovf;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_bytes     = r_rsp_bytes;
    assign rsp_error     = r_rsp_error;
endmodule
